cla: RTL and testbench



---
 rtl/cla.sv | 54 +++++
 tb/tb_cla.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cla.sv
// 4-bit carry-lookahead adder with registered sum and per-bit carry outputs.
// Every carry is a flat two-level AND-OR of generate/propagate terms and Cin.
module cla (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic [3:0] carry
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;
  logic [3:0] w_s;
  logic [3:0] r_sum;
  logic [3:0] r_carry;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // No carry term references another carry net, so no ripple chain forms.
  assign w_c[0] = w_g[0]
                | (w_p[0] & Cin);
  assign w_c[1] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & Cin);
  assign w_c[2] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign w_s = w_p ^ {w_c[2:0], Cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 4'b0000;
      r_carry <= 4'b0000;
    end else begin
      r_sum   <= w_s;
      r_carry <= w_c;
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_cla.sv
// Directed and exhaustive bench for cla: hand-computed vectors, reset and
// latency behaviour, then all 512 operand combinations against an integer model.
module tb_cla;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       Cin;
  logic [3:0] sum;
  logic [3:0] carry;

  int n_tests;
  int n_fail;

  cla u_dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .Cin   (Cin),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    @(negedge clk);
    a   = ia;
    b   = ib;
    Cin = ic;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_carry(input logic [3:0] ia, input logic [3:0] ib,
                                             input logic ic);
    logic [3:0] res;
    for (int i = 0; i < 4; i++) begin
      int mask;
      int tot;
      mask = (1 << (i + 1)) - 1;
      tot  = (int'(ia) & mask) + (int'(ib) & mask) + int'(ic);
      res[i] = tot[i+1];
    end
    return res;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a   = 4'd15;
    b   = 4'd15;
    Cin = 1'b1;

    // Reset held with clock running and all-ones inputs.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_sum", {4'b0, sum}, 8'h00);
      check("rst_carry", {4'b0, carry}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_sum", {4'b0, sum}, 8'b0000_1111);
    check("rel_carry", {4'b0, carry}, 8'b0000_1111);

    apply(4'd6, 4'd2, 1'b0);
    check("v6_2_sum", {4'b0, sum}, 8'b0000_1000);
    check("v6_2_carry", {4'b0, carry}, 8'b0000_0110);
    apply(4'd3, 4'd10, 1'b0);
    check("v3_10_sum", {4'b0, sum}, 8'b0000_1101);
    check("v3_10_carry", {4'b0, carry}, 8'b0000_0010);
    apply(4'd11, 4'd10, 1'b1);
    check("v11_10_sum", {4'b0, sum}, 8'b0000_0110);
    check("v11_10_carry", {4'b0, carry}, 8'b0000_1011);
    apply(4'd0, 4'd0, 1'b0);
    check("v0_0_sum", {4'b0, sum}, 8'b0000_0000);
    check("v0_0_carry", {4'b0, carry}, 8'b0000_0000);
    apply(4'd9, 4'd0, 1'b1);
    check("v9_0_sum", {4'b0, sum}, 8'b0000_1010);
    check("v9_0_carry", {4'b0, carry}, 8'b0000_0001);
    apply(4'd15, 4'd15, 1'b1);
    check("v15_15_sum", {4'b0, sum}, 8'b0000_1111);
    check("v15_15_carry", {4'b0, carry}, 8'b0000_1111);

    // Mid-cycle input change must not reach the outputs before the next edge.
    #1;
    a   = 4'd6;
    b   = 4'd2;
    Cin = 1'b0;
    #2;
    check("hold_sum", {4'b0, sum}, 8'b0000_1111);
    check("hold_carry", {4'b0, carry}, 8'b0000_1111);
    @(posedge clk);
    #1;
    check("upd_sum", {4'b0, sum}, 8'b0000_1000);
    check("upd_carry", {4'b0, carry}, 8'b0000_0110);

    // Reset pulse between edges clears at once, then the next edge reloads.
    a   = 4'd11;
    b   = 4'd10;
    Cin = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("pulse_sum", {4'b0, sum}, 8'h00);
    check("pulse_carry", {4'b0, carry}, 8'h00);
    rst = 1'b0;
    #1;
    check("post_pulse_sum", {4'b0, sum}, 8'h00);
    @(posedge clk);
    #1;
    check("reload_sum", {4'b0, sum}, 8'b0000_0110);
    check("reload_carry", {4'b0, carry}, 8'b0000_1011);

    // Exhaustive sweep.
    for (int x = 0; x < 512; x++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      int         tot;
      ea  = x[3:0];
      eb  = x[7:4];
      ec  = x[8];
      tot = int'(ea) + int'(eb) + int'(ec);
      apply(ea, eb, ec);
      check("exh_total", {3'b0, carry[3], sum}, tot[7:0]);
      check("exh_carry", {4'b0, carry}, {4'b0, model_carry(ea, eb, ec)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
